card_shoe: RTL and testbench
============================

# card_shoe

Parametrised multi-deck card source for the blackjack datapath; it is the next-generation replacement for the single-deck draw engine. It holds a shoe of `NUM_DECKS` × 52 cards as an in-place permutation and deals without replacement using LFSR-driven index selection. It serves `deal_player` / `deal_dealer` requests from the game FSM, reports remaining cards and a cut-card flag, and reshuffles in one cycle.

## Interface
- `NUM_DECKS`, default 1: decks in shoe; D = 52*NUM_DECKS, legal 1..8.
- `CUT_CARDS`, default 15: `cut_reached` asserts when cards_left < CUT_CARDS.
- `SEED`, default 16'hACE1: LFSR reset value; 0 is replaced by 16'hACE1.
- `clk  in  1`: single clock, rising edge.
- `rst  in  1`: reset, asynchronous, active-high.
- `draw_req  in  1`: request one card; sampled only in IDLE.
- `shuffle_req  in  1`: return all cards to the shoe.
- `card_valid  out  1`: one-cycle pulse; `card_data` and `card_rank` are valid.
- `card_data  out  7`: {suit[6:5], face[4], value[3:0]}; value 1..10, ace=1, J/Q/K value 10 with face=1.
- `card_rank  out  4`: 1..13 (A..K).
- `draw_err  out  1`: one-cycle pulse when a draw is requested with cards_left==0.
- `busy  out  1`: state != IDLE.
- `load_done  out  1`: shoe initialised.
- `cards_left  out  $clog2(D+1)`: undealt cards.
- `cut_reached  out  1`: cards_left < CUT_CARDS.

## Operation
- Storage: array `mem[D]` of 6-bit card indices 0..51, with combinational read. Index i decodes as suit = i/13, rank = i%13+1.
- States: LOAD, IDLE, PICK, SWAP.
- LOAD:
  - Writes mem[k] = k mod 52, one entry per cycle, for D cycles.
  - Then sets cards_left = D and load_done = 1, and enters IDLE.
  - draw_req and shuffle_req are ignored during LOAD.
- IDLE:
  - If shuffle_req is high, or a shuffle is pending: cards_left <= D, no memory writes, clear the pending flag, and stay in IDLE. Shuffle beats draw in the same cycle; the draw is dropped.
  - Else if draw_req and cards_left==0: pulse draw_err and stay in IDLE.
  - Else if draw_req: enter PICK with tries=0.
- PICK, one attempt per cycle:
  - Compute mask = bit-smear(cards_left-1) and cand = lfsr & mask.
  - If cand < cards_left: r = cand, go to SWAP.
  - Else if tries==3: r = cand - cards_left, go to SWAP. This fold is always in range because cand ≤ 2*cards_left-1.
  - Else: tries++ and stay in PICK.
- SWAP:
  - Let a = mem[r], b = mem[cards_left-1].
  - Write mem[r] <= b and mem[cards_left-1] <= a. The array therefore always remains a permutation.
  - Decode a into card_data / card_rank, pulse card_valid, decrement cards_left, return to IDLE.
- shuffle_req while busy is latched as pending and applied on the first IDLE cycle, before any draw.
- Reset values:
  - state LOAD; all counters 0.
  - card_valid, draw_err, load_done, busy(=1 in LOAD) per state.
  - card_data = 0, card_rank = 0, cards_left = 0.
  - cut_reached = 1 (0 < CUT_CARDS).
- Reset mid-draw: the draw is aborted with no card_valid, and the shoe fully reloads.

## Timing
- The draw_req sampling edge N moves the FSM to PICK. The accepting PICK edge is N+t, t in 1..4. SWAP happens at edge N+t+1, and card_valid is high during the following cycle.
- Latency is 2..5 cycles from the sampling edge. The bound is hard.
- card_data and card_rank hold until the next SWAP.
- A held draw_req yields back-to-back draws; the next is sampled on the edge ending the card_valid cycle.
- Shuffle costs 1 cycle.
- LOAD lasts D cycles after rst deasserts.
- cut_reached and cards_left update on the SWAP edge.

## Configuration
- Macro: `CARD_SHOE_ENTROPY_EN`.
- Defined: the LFSR advances every clock, including LOAD and IDLE. Deal order then depends on request timing, which is the mode for play.
- Undefined: the LFSR advances only on PICK cycles. The sequence is a pure function of SEED and the request/shuffle order, which is the mode for verification.

## Structure
- `card_pkg` holds:
  - `card_t` packed struct {suit, face, value}
  - suit enum (spades, hearts, diamonds, clubs)
  - constants CARDS_PER_DECK = 52 and RANKS = 13
  - function `idx_to_card(6-bit) -> card_t`
- Sub-module `shoe_lfsr`:
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Ports: clk, rst, adv, q.
  - Never reaches zero.

## Test plan
- Reset/load, NUM_DECKS=1: release rst, then load_done rises exactly 52 cycles later, cards_left=52, cut_reached=0.
- Full deal: 52 draws give each of the 52 codes exactly once, every latency is in 2..5, and cut_reached rises when cards_left=14. The 53rd draw gives draw_err=1 and no card_valid.
- Shuffle:
  - After 20 draws, pulse shuffle_req: cards_left=52 one cycle later.
  - Next 52 draws give a full set again.
  - shuffle_req together with draw_req gives no card_valid.
- Determinism, macro undefined: two runs with SEED=16'h1234 and identical stimulus produce identical card sequences. SEED=0 behaves as 16'hACE1.
- NUM_DECKS=2, CUT_CARDS=30: load takes 104 cycles, 104 draws give every code exactly twice, and cut_reached rises at cards_left=29.
- Reset mid-draw: assert rst during PICK, so there is no card_valid, then the reload completes and cards_left=D.

Source files
------------

// File: rtl/card_pkg.sv
// rtl/card_pkg.sv - card encoding types, shoe constants and index decode helpers
package card_pkg;

    localparam int CARDS_PER_DECK = 52;
    localparam int RANKS          = 13;

    typedef enum logic [1:0] {
        SUIT_SPADES   = 2'd0,
        SUIT_HEARTS   = 2'd1,
        SUIT_DIAMONDS = 2'd2,
        SUIT_CLUBS    = 2'd3
    } suit_e;

    typedef struct packed {
        suit_e      suit;
        logic       face;
        logic [3:0] value;
    } card_t;

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_IDLE = 2'd1,
        S_PICK = 2'd2,
        S_SWAP = 2'd3
    } shoe_state_e;

    // suit = idx / 13 as range compares instead of a divider
    function automatic logic [1:0] idx_to_suit(input logic [5:0] idx);
        if (idx >= 6'd39)      return 2'd3;
        else if (idx >= 6'd26) return 2'd2;
        else if (idx >= 6'd13) return 2'd1;
        else                   return 2'd0;
    endfunction

    // rank = idx % 13 + 1, giving 1..13 (A..K)
    function automatic logic [3:0] idx_to_rank(input logic [5:0] idx);
        logic [5:0] base;
        logic [5:0] off;
        case (idx_to_suit(idx))
            2'd0:    base = 6'd0;
            2'd1:    base = 6'd13;
            2'd2:    base = 6'd26;
            default: base = 6'd39;
        endcase
        off = idx - base;
        return off[3:0] + 4'd1;
    endfunction

    function automatic card_t idx_to_card(input logic [5:0] idx);
        card_t      c;
        logic [3:0] rank;
        rank    = idx_to_rank(idx);
        c.suit  = suit_e'(idx_to_suit(idx));
        c.face  = (rank > 4'd10);
        c.value = c.face ? 4'd10 : rank;
        return c;
    endfunction

endpackage

// File: rtl/shoe_lfsr.sv
// rtl/shoe_lfsr.sv - 16-bit Galois LFSR, x^16+x^14+x^13+x^11+1
// Ports: clk, rst (async, active-high), adv (step enable), q (state, never zero)
module shoe_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        adv,
    output logic [15:0] q
);

    // An all-zero state would lock the register, so a zero seed is replaced
    localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'hACE1 : SEED;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= INIT;
        end else if (adv) begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? 16'hB400 : 16'h0000);
        end
    end

endmodule

// File: rtl/card_shoe.sv
// rtl/card_shoe.sv - multi-deck card shoe dealing without replacement via LFSR index picks
// Ports: clk, rst (async, active-high); draw_req, shuffle_req in;
//        card_valid, card_data {suit,face,value}, card_rank, draw_err, busy,
//        load_done, cards_left, cut_reached out.
// Build option: CARD_SHOE_ENTROPY_EN makes the LFSR free-run on every clock.
module card_shoe
    import card_pkg::*;
#(
    parameter int          NUM_DECKS = 1,
    parameter int          CUT_CARDS = 15,
    parameter logic [15:0] SEED      = 16'hACE1,
    localparam int         D         = CARDS_PER_DECK * NUM_DECKS,
    localparam int         CW        = $clog2(D + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          draw_req,
    input  logic          shuffle_req,
    output logic          card_valid,
    output logic [6:0]    card_data,
    output logic [3:0]    card_rank,
    output logic          draw_err,
    output logic          busy,
    output logic          load_done,
    output logic [CW-1:0] cards_left,
    output logic          cut_reached
);

    shoe_state_e   state;
    logic [CW-1:0] load_k;
    logic [5:0]    load_m;
    logic [1:0]    tries;
    logic [CW-1:0] r;
    logic          pend;
    logic [15:0]   lfsr_q;
    logic          lfsr_adv;

    // Undealt cards live in mem[0 .. cards_left-1]; dealt ones sit above
    logic [5:0]    mem [D];

    logic [CW-1:0] left_m1;
    logic [CW-1:0] mask;
    logic [CW-1:0] cand;
    logic [5:0]    a;
    logic [5:0]    b;
    logic          unused_lfsr_hi;

    function automatic logic [CW-1:0] smear(input logic [CW-1:0] x);
        logic [CW-1:0] m;
        m = x;
        for (int s = 1; s < CW; s = s * 2) m = m | (m >> s);
        return m;
    endfunction

`ifdef CARD_SHOE_ENTROPY_EN
    assign lfsr_adv = 1'b1;
`else
    assign lfsr_adv = (state == S_PICK);
`endif

    shoe_lfsr #(.SEED(SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .adv (lfsr_adv),
        .q   (lfsr_q)
    );

    // Masking to the smallest 2^n-1 covering cards_left-1 keeps cand < 2*cards_left
    assign left_m1        = cards_left - 1'b1;
    assign mask           = smear(left_m1);
    assign cand           = lfsr_q[CW-1:0] & mask;
    assign a              = mem[r];
    assign b              = mem[left_m1];
    assign unused_lfsr_hi = ^lfsr_q[15:CW];

    assign busy        = (state != S_IDLE);
    assign cut_reached = (32'(cards_left) < CUT_CARDS);

    always_ff @(posedge clk) begin
        if (state == S_LOAD) begin
            mem[load_k] <= load_m;
        end else if (state == S_SWAP) begin
            mem[r]       <= b;
            mem[left_m1] <= a;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_LOAD;
            load_k     <= '0;
            load_m     <= '0;
            tries      <= '0;
            r          <= '0;
            pend       <= 1'b0;
            cards_left <= '0;
            load_done  <= 1'b0;
            card_valid <= 1'b0;
            draw_err   <= 1'b0;
            card_data  <= '0;
            card_rank  <= '0;
        end else begin
            card_valid <= 1'b0;
            draw_err   <= 1'b0;
            case (state)
                S_LOAD: begin
                    load_k <= load_k + 1'b1;
                    load_m <= (load_m == 6'd51) ? 6'd0 : load_m + 6'd1;
                    if (load_k == CW'(D - 1)) begin
                        cards_left <= CW'(D);
                        load_done  <= 1'b1;
                        state      <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    // Shuffle only rewinds the count; the array stays a valid permutation
                    if (shuffle_req || pend) begin
                        cards_left <= CW'(D);
                        pend       <= 1'b0;
                    end else if (draw_req) begin
                        if (cards_left == '0) begin
                            draw_err <= 1'b1;
                        end else begin
                            tries <= 2'd0;
                            state <= S_PICK;
                        end
                    end
                end
                S_PICK: begin
                    if (shuffle_req) pend <= 1'b1;
                    if (cand < cards_left) begin
                        r     <= cand;
                        state <= S_SWAP;
                    end else if (tries == 2'd3) begin
                        // Last attempt folds into range to bound latency
                        r     <= cand - cards_left;
                        state <= S_SWAP;
                    end else begin
                        tries <= tries + 2'd1;
                    end
                end
                S_SWAP: begin
                    if (shuffle_req) pend <= 1'b1;
                    card_data  <= idx_to_card(a);
                    card_rank  <= idx_to_rank(a);
                    card_valid <= 1'b1;
                    cards_left <= left_m1;
                    state      <= S_IDLE;
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_card_shoe.sv
// tb/tb_card_shoe.sv - directed self-checking bench for card_shoe (1-deck and 2-deck, SEED=0)
module tb_card_shoe;

    logic       clk = 1'b0;
    logic       rst;
    logic       draw_req, shuffle_req, draw_req2, shuffle_req2;

    logic       card_valid, draw_err, busy, load_done, cut_reached;
    logic [6:0] card_data;
    logic [3:0] card_rank;
    logic [5:0] cards_left;

    logic       card_valid2, draw_err2, busy2, load_done2, cut_reached2;
    logic [6:0] card_data2;
    logic [3:0] card_rank2;
    logic [6:0] cards_left2;

    int vectors = 0;
    int miscompares = 0;

    // reference shoe model per instance
    int          mm [2][416];
    int          ml [2];
    logic [15:0] mlf[2];
    int          cnt[52];

    always #5 clk = ~clk;

    card_shoe dut (
        .clk(clk), .rst(rst), .draw_req(draw_req), .shuffle_req(shuffle_req),
        .card_valid(card_valid), .card_data(card_data), .card_rank(card_rank),
        .draw_err(draw_err), .busy(busy), .load_done(load_done),
        .cards_left(cards_left), .cut_reached(cut_reached)
    );

    card_shoe #(.NUM_DECKS(2), .CUT_CARDS(30), .SEED(16'h0000)) dut2 (
        .clk(clk), .rst(rst), .draw_req(draw_req2), .shuffle_req(shuffle_req2),
        .card_valid(card_valid2), .card_data(card_data2), .card_rank(card_rank2),
        .draw_err(draw_err2), .busy(busy2), .load_done(load_done2),
        .cards_left(cards_left2), .cut_reached(cut_reached2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic model_reset(input int s, input int d);
        for (int k = 0; k < d; k++) mm[s][k] = k % 52;
        ml[s]  = d;
        mlf[s] = 16'hACE1;
    endtask

    task automatic model_draw(input int s, output int code, output int tries);
        int left, mask, cand, r;
        bit done;
        left = ml[s];
        mask = left - 1;
        mask = mask | (mask >> 1);
        mask = mask | (mask >> 2);
        mask = mask | (mask >> 4);
        mask = mask | (mask >> 8);
        done = 0; r = 0; tries = 0;
        for (int k = 0; k < 4; k++) begin
            if (!done) begin
                cand   = int'(mlf[s]) & mask;
                mlf[s] = lfsr_step(mlf[s]);
                if (cand < left) begin r = cand; tries = k; done = 1; end
                else if (k == 3) begin r = cand - left; tries = 3; done = 1; end
            end
        end
        code              = mm[s][r];
        mm[s][r]          = mm[s][left - 1];
        mm[s][left - 1]   = code;
        ml[s]             = left - 1;
    endtask

    function automatic int exp_data(input int code);
        int rank, face;
        rank = code % 13 + 1;
        face = (rank > 10) ? 1 : 0;
        return ((code / 13) << 5) | (face << 4) | (face ? 10 : rank);
    endfunction

    function automatic logic get_cv(input int s);
        return s ? card_valid2 : card_valid;
    endfunction

    // one draw with exact latency, card and count check against the model
    task automatic do_draw(input int s, input int cut, input string tag);
        int code, tries, lat;
        bit seen;
        model_draw(s, code, tries);
        if (s == 0) draw_req = 1'b1; else draw_req2 = 1'b1;
        tick();
        draw_req = 1'b0; draw_req2 = 1'b0;
        seen = 0; lat = 0;
        for (int c = 1; c <= 8; c++) begin
            if (!seen) begin
                tick();
                if (get_cv(s)) begin seen = 1; lat = c; end
            end
        end
        check({tag, ".lat"}, lat, tries + 2);
        if (seen) begin
            check({tag, ".data"}, s ? card_data2 : card_data, exp_data(code));
            check({tag, ".rank"}, s ? card_rank2 : card_rank, code % 13 + 1);
            check({tag, ".left"}, s ? cards_left2 : cards_left, ml[s]);
            check({tag, ".cut"}, s ? cut_reached2 : cut_reached, (ml[s] < cut) ? 1 : 0);
            cnt[code]++;
        end
    endtask

    task automatic clear_counts();
        for (int k = 0; k < 52; k++) cnt[k] = 0;
    endtask

    task automatic check_counts(input string tag, input int want);
        for (int k = 0; k < 52; k++) check($sformatf("%s.code%0d", tag, k), cnt[k], want);
    endtask

    initial begin
        int ld1, ld2, ncv;
        bit err_ok;
        rst = 1'b1; draw_req = 0; shuffle_req = 0; draw_req2 = 0; shuffle_req2 = 0;
        tick(); tick(); tick();
        check("rst.card_valid", card_valid, 0);
        check("rst.load_done", load_done, 0);
        check("rst.busy", busy, 1);
        check("rst.cards_left", cards_left, 0);
        check("rst.cut", cut_reached, 1);
        check("rst.card_data", card_data, 0);
        check("rst.card_rank", card_rank, 0);

        rst = 1'b0;
        model_reset(0, 52);
        model_reset(1, 104);
        ld1 = 0; ld2 = 0;
        for (int c = 1; c <= 110; c++) begin
            tick();
            if (load_done && ld1 == 0) begin
                ld1 = c;
                check("load.cards_left", cards_left, 52);
                check("load.cut", cut_reached, 0);
                check("load.busy", busy, 0);
            end
            if (load_done2 && ld2 == 0) begin
                ld2 = c;
                check("load2.cards_left", cards_left2, 104);
            end
        end
        check("load.cycles", ld1, 52);
        check("load2.cycles", ld2, 104);

        clear_counts();
        for (int i = 0; i < 52; i++) do_draw(0, 15, $sformatf("deal%0d", i));
        check_counts("deal", 1);

        draw_req = 1'b1;
        tick();
        draw_req = 1'b0;
        check("empty.draw_err", draw_err, 1);
        check("empty.card_valid", card_valid, 0);
        tick();
        check("empty.err_pulse", draw_err, 0);
        ncv = 0;
        for (int c = 0; c < 5; c++) begin tick(); if (card_valid) ncv++; end
        check("empty.no_card", ncv, 0);

        shuffle_req = 1'b1;
        tick();
        shuffle_req = 1'b0;
        ml[0] = 52;
        check("shuf1.cards_left", cards_left, 52);
        for (int i = 0; i < 20; i++) do_draw(0, 15, $sformatf("part%0d", i));
        shuffle_req = 1'b1;
        tick();
        shuffle_req = 1'b0;
        ml[0] = 52;
        check("shuf2.cards_left", cards_left, 52);
        check("shuf2.cut", cut_reached, 0);
        clear_counts();
        for (int i = 0; i < 52; i++) do_draw(0, 15, $sformatf("redeal%0d", i));
        check_counts("redeal", 1);

        // shuffle and draw in the same cycle: shuffle wins, no card
        draw_req = 1'b1; shuffle_req = 1'b1;
        tick();
        draw_req = 1'b0; shuffle_req = 1'b0;
        ml[0] = 52;
        check("both.cards_left", cards_left, 52);
        ncv = 0;
        for (int c = 0; c < 6; c++) begin tick(); if (card_valid) ncv++; end
        check("both.no_card", ncv, 0);

        // shuffle while busy is held pending until the next IDLE cycle
        begin
            int code, tries, lat;
            model_draw(0, code, tries);
            draw_req = 1'b1;
            tick();
            draw_req = 1'b0; shuffle_req = 1'b1;
            tick();
            shuffle_req = 1'b0;
            lat = card_valid ? 1 : 0;
            for (int c = 2; c <= 8; c++) if (lat == 0) begin tick(); if (card_valid) lat = c; end
            check("pend.lat", lat, tries + 2);
            check("pend.data", card_data, exp_data(code));
            check("pend.left", cards_left, 51);
            tick();
            ml[0] = 52;
            check("pend.applied", cards_left, 52);
        end
        do_draw(0, 15, "after_pend");

        clear_counts();
        for (int i = 0; i < 104; i++) do_draw(1, 30, $sformatf("deck2_%0d", i));
        check_counts("deck2", 2);
        check("deck2.empty", cards_left2, 0);

        // reset while PICK is active
        draw_req = 1'b1;
        tick();
        draw_req = 1'b0;
        rst = 1'b1;
        #1;
        check("rstmid.card_valid", card_valid, 0);
        check("rstmid.cards_left", cards_left, 0);
        check("rstmid.busy", busy, 1);
        tick(); tick();
        rst = 1'b0;
        model_reset(0, 52);
        ld1 = 0; ncv = 0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (card_valid) ncv++;
            if (load_done && ld1 == 0) ld1 = c;
        end
        check("rstmid.no_card", ncv, 0);
        check("rstmid.reload", ld1, 52);
        check("rstmid.left", cards_left, 52);
        do_draw(0, 15, "post_reset");

        err_ok = (miscompares == 0);
        if (!err_ok) $display("run ended with %0d bad vectors", miscompares);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
